ctrl_fsm_multicycle: RTL and testbench
======================================

# ctrl_fsm_multicycle

Multi-cycle control sequencer for the KGPminiRISC datapath; the sequential successor to the single-cycle opcode decoder. It walks each instruction through fetch, decode, execute, memory and writeback states, and issues per-state datapath controls. It waits on a ready/request handshake with instruction/data memory, owns the architectural carry flag, resolves conditional branches and counts retired instructions. It sits between the instruction register and the datapath multiplexers, register file and ALU.

## Interface
Parameters:
- OPW, 6, opcode width
- ALUOPW, 2, ALU operation select width
- CNTW, 32, retired-instruction counter width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPW  IR opcode field, valid from DECODE onward
- mem_ready  in  1  memory completes the current request this cycle
- alu_carry  in  1  ALU carry-out of the current EXEC operation
- rs_zero  in  1  rs operand == 0, valid in BRANCH
- rs_neg  in  1  rs operand MSB, valid in BRANCH
- mem_req  out  1  memory request, held until mem_ready
- ir_write  out  1  load IR from memory data
- pc_inc  out  1  PC <= PC+4
- pc_write  out  1  PC <= branch target selected by AddrSel
- RegWrite  out  1  register-file write enable
- RegDst  out  2  00 rd, 01 rt, 10 r31 (link)
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemToReg  out  2  00 ALU, 01 memory, 10 PC (link)
- ALUop  out  ALUOPW  00 R-type, 01 immediate, 10 address add, 11 pass-through
- ALUsrc  out  1  0 register, 1 immediate
- AddrSel  out  2  00 PC-relative, 01 register, 10 conditional PC-relative
- carry_flag  out  1  architectural carry
- retired  out  CNTW  instructions retired, wraps modulo 2^CNTW
- halted  out  1  HALT state
- illegal  out  1  TRAP state, sticky

## Operation
- Opcodes: 0 R-type, 1 I-type, 2 lw, 3 sw, 4 br, 5 bltz, 6 bz, 7 bnz, 8 b, 9 bl, 10 bcy, 11 bncy, all-ones halt. Any other opcode is illegal.
- Every output is deasserted or zero in any state that does not drive it. There is no latched leftover.
- FETCH: mem_req=1 and MemRead=1. On mem_ready, pulse ir_write=1 and pc_inc=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE: one cycle with no side effects.
  - R/I-type go to EXEC.
  - lw and sw go to ADDR.
  - Branches go to BRANCH.
  - halt goes to HALT.
  - Illegal opcodes go to TRAP.
- EXEC: ALUop is 00 for R-type, or 01 with ALUsrc=1 for I-type. carry_flag <= alu_carry at the end of the cycle. Then go to WB.
- ADDR: ALUop=10, ALUsrc=1. Then go to MEM.
- MEM: mem_req=1, plus MemRead for lw or MemWrite for sw, held until mem_ready.
  - lw goes to WB.
  - sw retires and goes to FETCH.
- WB: RegWrite=1, RegDst=00 for R-type or 01 for I-type and lw, MemToReg=01 for lw else 00. Retire, then go to FETCH.
- BRANCH: evaluate taken for the latched opcode.
  - br, b and bl are always taken.
  - bltz takes rs_neg; bz takes rs_zero; bnz takes !rs_zero.
  - bcy takes carry_flag; bncy takes !carry_flag.
  - pc_write = taken. AddrSel is 01 for br, 10 for bltz/bz/bnz, 00 otherwise.
  - For bl, also RegWrite=1, RegDst=10, MemToReg=10 in the same cycle.
  - Retire, then go to FETCH.
- HALT and TRAP are absorbing; only rst leaves them.
- Retire means retired <= retired+1.

## Timing
- Reset, asynchronous: state FETCH, all outputs 0, carry_flag 0, retired 0. FETCH asserts mem_req on the first clock edge after rst deasserts.
- Latencies with zero-wait memory (mem_ready high on the first request cycle):
  - R/I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch: 3 cycles.
- Each wait cycle adds 1 cycle.
- mem_req and the strobes stay stable while mem_ready is low. They drop the cycle after the mem_ready cycle.
- rst during a MEM wait aborts the access. No strobe is asserted after the asynchronous reset edge.
- Branches read carry_flag as updated by the most recent EXEC. No EXEC and BRANCH ever occur in the same cycle.
- retired wraps from all-ones to 0 with no flag.

## Structure
- ctrl_pkg holds:
  - the opcode localparams
  - the state enum (FETCH, DECODE, EXEC, ADDR, MEM, WB, BRANCH, HALT, TRAP)
  - the RegDst, MemToReg, ALUop and AddrSel encodings
- Sub-module branch_cond_eval: combinational taken logic from opcode, rs_zero, rs_neg and carry_flag.

## Test plan
- Reset then R-type with mem_ready always 1 -> ir_write in cycle 1, RegWrite in cycle 4, retired=1, all strobes 0 elsewhere.
- lw with mem_ready low for 3 MEM cycles -> MemRead and mem_req held 4 cycles, then WB with MemToReg=01 and RegDst=01, total 8 cycles.
- I-type with alu_carry=1, then bcy -> pc_write=1, AddrSel=00. Repeat with bncy -> pc_write=0, retired still increments.
- bl -> single BRANCH cycle with pc_write=1, RegWrite=1, RegDst=10, MemToReg=10.
- opcode 6'b010101 -> TRAP, illegal=1 held for 20 cycles, mem_req never reasserted. rst clears it.
- rst asserted mid-MEM of sw with mem_ready=0 -> MemWrite and mem_req fall asynchronously; FETCH follows release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcode map, FSM state type and datapath select encodings for the
// KGPminiRISC multi-cycle control sequencer.
package ctrl_pkg;

  localparam int OP_R    = 0;
  localparam int OP_I    = 1;
  localparam int OP_LW   = 2;
  localparam int OP_SW   = 3;
  localparam int OP_BR   = 4;
  localparam int OP_BLTZ = 5;
  localparam int OP_BZ   = 6;
  localparam int OP_BNZ  = 7;
  localparam int OP_B    = 8;
  localparam int OP_BL   = 9;
  localparam int OP_BCY  = 10;
  localparam int OP_BNCY = 11;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, ADDR, MEM, WB, BRANCH, HALT, TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BRANCH, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  localparam logic [1:0] REGDST_RD   = 2'b00;
  localparam logic [1:0] REGDST_RT   = 2'b01;
  localparam logic [1:0] REGDST_LINK = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;

  localparam logic [1:0] ALU_R    = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_ADDR = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  localparam logic [1:0] ADDRSEL_PCREL = 2'b00;
  localparam logic [1:0] ADDRSEL_REG   = 2'b01;
  localparam logic [1:0] ADDRSEL_COND  = 2'b10;

  // The all-ones halt code depends on the opcode width, so the caller passes it in.
  function automatic op_class_t classify(input int op, input logic all_ones);
    op_class_t cls;
    if (all_ones) begin
      cls = CLS_HALT;
    end else begin
      case (op)
        OP_R:    cls = CLS_R;
        OP_I:    cls = CLS_I;
        OP_LW:   cls = CLS_LW;
        OP_SW:   cls = CLS_SW;
        OP_BR, OP_BLTZ, OP_BZ, OP_BNZ, OP_B, OP_BL, OP_BCY, OP_BNCY:
                 cls = CLS_BRANCH;
        default: cls = CLS_ILLEGAL;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-taken evaluation for the latched branch opcode.
module branch_cond_eval
  import ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  input  logic           rs_zero,
  input  logic           rs_neg,
  input  logic           carry_flag,
  output logic           taken
);

  always_comb begin
    taken = 1'b0;
    case (int'(opcode))
      OP_BR, OP_B, OP_BL: taken = 1'b1;
      OP_BLTZ:            taken = rs_neg;
      OP_BZ:              taken = rs_zero;
      OP_BNZ:             taken = !rs_zero;
      OP_BCY:             taken = carry_flag;
      OP_BNCY:            taken = !carry_flag;
      default:            taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm_multicycle.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/ADDR/MEM/WB/BRANCH walk with
// memory handshake, carry flag ownership and a retired-instruction counter.
module ctrl_fsm_multicycle
  import ctrl_pkg::*;
#(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2,
  parameter int CNTW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW-1:0]    opcode,
  input  logic              mem_ready,
  input  logic              alu_carry,
  input  logic              rs_zero,
  input  logic              rs_neg,
  output logic              mem_req,
  output logic              ir_write,
  output logic              pc_inc,
  output logic              pc_write,
  output logic              RegWrite,
  output logic [1:0]        RegDst,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [1:0]        MemToReg,
  output logic [ALUOPW-1:0] ALUop,
  output logic              ALUsrc,
  output logic [1:0]        AddrSel,
  output logic              carry_flag,
  output logic [CNTW-1:0]   retired,
  output logic              halted,
  output logic              illegal
);

  state_t         state, next_state;
  logic           run;
  logic [OPW-1:0] op_q;
  op_class_t      cls;
  int             op_int;
  logic           taken;
  logic           carry_en;
  logic           retire;
  logic [1:0]     alu_sel;

  assign op_int = int'(op_q);
  assign cls    = classify(op_int, &op_q);
  assign ALUop  = ALUOPW'(alu_sel);

  branch_cond_eval #(.OPW(OPW)) u_branch_cond_eval (
    .opcode     (op_q),
    .rs_zero    (rs_zero),
    .rs_neg     (rs_neg),
    .carry_flag (carry_flag),
    .taken      (taken)
  );

  // run holds everything quiet until the first clock edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      run        <= 1'b0;
      op_q       <= '0;
      carry_flag <= 1'b0;
      retired    <= '0;
    end else begin
      run <= 1'b1;
      if (run) state <= next_state;
      if (state == DECODE) op_q <= opcode;
      if (carry_en) carry_flag <= alu_carry;
      if (retire) retired <= retired + CNTW'(1);
    end
  end

  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_write   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = REGDST_RD;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = MTR_ALU;
    alu_sel    = ALU_R;
    ALUsrc     = 1'b0;
    AddrSel    = ADDRSEL_PCREL;
    halted     = 1'b0;
    illegal    = 1'b0;
    carry_en   = 1'b0;
    retire     = 1'b0;
    if (run) begin
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_inc     = 1'b1;
            next_state = DECODE;
          end
        end
        DECODE: begin
          case (classify(int'(opcode), &opcode))
            CLS_R, CLS_I:   next_state = EXEC;
            CLS_LW, CLS_SW: next_state = ADDR;
            CLS_BRANCH:     next_state = BRANCH;
            CLS_HALT:       next_state = HALT;
            default:        next_state = TRAP;
          endcase
        end
        EXEC: begin
          alu_sel    = (cls == CLS_I) ? ALU_IMM : ALU_R;
          ALUsrc     = (cls == CLS_I);
          carry_en   = 1'b1;
          next_state = WB;
        end
        ADDR: begin
          alu_sel    = ALU_ADDR;
          ALUsrc     = 1'b1;
          next_state = MEM;
        end
        MEM: begin
          mem_req  = 1'b1;
          MemRead  = (cls == CLS_LW);
          MemWrite = (cls == CLS_SW);
          if (mem_ready) begin
            if (cls == CLS_LW) begin
              next_state = WB;
            end else begin
              retire     = 1'b1;
              next_state = FETCH;
            end
          end
        end
        WB: begin
          RegWrite   = 1'b1;
          RegDst     = (cls == CLS_R) ? REGDST_RD : REGDST_RT;
          MemToReg   = (cls == CLS_LW) ? MTR_MEM : MTR_ALU;
          retire     = 1'b1;
          next_state = FETCH;
        end
        BRANCH: begin
          pc_write = taken;
          if (op_int == OP_BR)
            AddrSel = ADDRSEL_REG;
          else if (op_int == OP_BLTZ || op_int == OP_BZ || op_int == OP_BNZ)
            AddrSel = ADDRSEL_COND;
          else
            AddrSel = ADDRSEL_PCREL;
          if (op_int == OP_BL) begin
            RegWrite = 1'b1;
            RegDst   = REGDST_LINK;
            MemToReg = MTR_PC;
          end
          retire     = 1'b1;
          next_state = FETCH;
        end
        HALT:    halted  = 1'b1;
        TRAP:    illegal = 1'b1;
        default: next_state = TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm_multicycle.sv
// Scoreboard bench for ctrl_fsm_multicycle: the driver queues a per-cycle
// expected control snapshot for each instruction, the monitor pops and compares.
module tb_ctrl_fsm_multicycle;

  localparam logic [5:0] T_R    = 6'd0;
  localparam logic [5:0] T_I    = 6'd1;
  localparam logic [5:0] T_LW   = 6'd2;
  localparam logic [5:0] T_SW   = 6'd3;
  localparam logic [5:0] T_BR   = 6'd4;
  localparam logic [5:0] T_BLTZ = 6'd5;
  localparam logic [5:0] T_BZ   = 6'd6;
  localparam logic [5:0] T_BNZ  = 6'd7;
  localparam logic [5:0] T_B    = 6'd8;
  localparam logic [5:0] T_BL   = 6'd9;
  localparam logic [5:0] T_BCY  = 6'd10;
  localparam logic [5:0] T_BNCY = 6'd11;
  localparam logic [5:0] T_HALT = 6'd63;
  localparam logic [5:0] T_ILL  = 6'b010101;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready, alu_carry, rs_zero, rs_neg;
  logic        mem_req, ir_write, pc_inc, pc_write, RegWrite;
  logic [1:0]  RegDst, MemToReg, ALUop, AddrSel;
  logic        MemRead, MemWrite, ALUsrc;
  logic        carry_flag, halted, illegal;
  logic [31:0] retired;

  typedef struct packed {
    logic        mem_req;
    logic        ir_write;
    logic        pc_inc;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_to_reg;
    logic [1:0]  alu_op;
    logic        alu_src;
    logic [1:0]  addr_sel;
    logic        halted;
    logic        illegal;
    logic        carry;
    logic [31:0] retired;
  } snap_t;

  snap_t      exp_q[$];
  string      name_q[$];
  logic [3:0] in_q[$];
  snap_t      mon_exp;
  string      mon_name;
  int         checks = 0;
  int         errors = 0;
  logic       m_carry;
  logic [31:0] m_retired;

  ctrl_fsm_multicycle #(.OPW(6), .ALUOPW(2), .CNTW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .alu_carry  (alu_carry),
    .rs_zero    (rs_zero),
    .rs_neg     (rs_neg),
    .mem_req    (mem_req),
    .ir_write   (ir_write),
    .pc_inc     (pc_inc),
    .pc_write   (pc_write),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .MemToReg   (MemToReg),
    .ALUop      (ALUop),
    .ALUsrc     (ALUsrc),
    .AddrSel    (AddrSel),
    .carry_flag (carry_flag),
    .retired    (retired),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  function automatic snap_t actual();
    snap_t a;
    a.mem_req    = mem_req;
    a.ir_write   = ir_write;
    a.pc_inc     = pc_inc;
    a.pc_write   = pc_write;
    a.reg_write  = RegWrite;
    a.reg_dst    = RegDst;
    a.mem_read   = MemRead;
    a.mem_write  = MemWrite;
    a.mem_to_reg = MemToReg;
    a.alu_op     = ALUop;
    a.alu_src    = ALUsrc;
    a.addr_sel   = AddrSel;
    a.halted     = halted;
    a.illegal    = illegal;
    a.carry      = carry_flag;
    a.retired    = retired;
    return a;
  endfunction

  function automatic snap_t blank();
    snap_t s;
    s         = '0;
    s.carry   = m_carry;
    s.retired = m_retired;
    return s;
  endfunction

  task automatic checkOutput(input string nm, input snap_t exp_s);
    snap_t act;
    act = actual();
    checks++;
    if (act !== exp_s) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", nm, act, exp_s);
    end
  endtask

  task automatic pushCycle(input string nm, input snap_t s, input logic rdy,
                           input logic cin, input logic rz, input logic rn);
    exp_q.push_back(s);
    name_q.push_back(nm);
    in_q.push_back({rdy, cin, rz, rn});
  endtask

  // Builds the expected trace for one instruction, then drives it cycle by cycle.
  task automatic applyStimulus(input string nm, input logic [5:0] op,
                               input int fetch_wait, input int mem_wait,
                               input logic cin, input logic rz, input logic rn,
                               input bit abort);
    snap_t s;
    logic  tk;
    for (int i = 0; i < fetch_wait; i++) begin
      s = blank(); s.mem_req = 1'b1; s.mem_read = 1'b1;
      pushCycle({nm, " fetch_wait"}, s, 1'b0, cin, rz, rn);
    end
    s = blank(); s.mem_req = 1'b1; s.mem_read = 1'b1; s.ir_write = 1'b1; s.pc_inc = 1'b1;
    pushCycle({nm, " fetch"}, s, 1'b1, cin, rz, rn);
    s = blank();
    pushCycle({nm, " decode"}, s, 1'b1, cin, rz, rn);
    case (op)
      T_R, T_I: begin
        s = blank();
        if (op == T_I) begin s.alu_op = 2'b01; s.alu_src = 1'b1; end
        pushCycle({nm, " exec"}, s, 1'b1, cin, rz, rn);
        m_carry = cin;
        s = blank(); s.reg_write = 1'b1;
        s.reg_dst = (op == T_I) ? 2'b01 : 2'b00;
        pushCycle({nm, " wb"}, s, 1'b1, cin, rz, rn);
        m_retired++;
      end
      T_LW, T_SW: begin
        s = blank(); s.alu_op = 2'b10; s.alu_src = 1'b1;
        pushCycle({nm, " addr"}, s, 1'b1, cin, rz, rn);
        s = blank(); s.mem_req = 1'b1;
        s.mem_read = (op == T_LW); s.mem_write = (op == T_SW);
        for (int i = 0; i < mem_wait; i++) pushCycle({nm, " mem_wait"}, s, 1'b0, cin, rz, rn);
        if (!abort) begin
          pushCycle({nm, " mem"}, s, 1'b1, cin, rz, rn);
          if (op == T_LW) begin
            s = blank(); s.reg_write = 1'b1; s.reg_dst = 2'b01; s.mem_to_reg = 2'b01;
            pushCycle({nm, " wb"}, s, 1'b1, cin, rz, rn);
          end
          m_retired++;
        end
      end
      T_BR, T_BLTZ, T_BZ, T_BNZ, T_B, T_BL, T_BCY, T_BNCY: begin
        case (op)
          T_BLTZ:  tk = rn;
          T_BZ:    tk = rz;
          T_BNZ:   tk = !rz;
          T_BCY:   tk = m_carry;
          T_BNCY:  tk = !m_carry;
          default: tk = 1'b1;
        endcase
        s = blank(); s.pc_write = tk;
        if (op == T_BR) s.addr_sel = 2'b01;
        else if (op == T_BLTZ || op == T_BZ || op == T_BNZ) s.addr_sel = 2'b10;
        if (op == T_BL) begin s.reg_write = 1'b1; s.reg_dst = 2'b10; s.mem_to_reg = 2'b10; end
        pushCycle({nm, " branch"}, s, 1'b1, cin, rz, rn);
        m_retired++;
      end
      T_HALT: begin
        s = blank(); s.halted = 1'b1;
        for (int i = 0; i < 5; i++) pushCycle({nm, " halt"}, s, 1'b1, cin, rz, rn);
      end
      default: begin
        s = blank(); s.illegal = 1'b1;
        for (int i = 0; i < 20; i++) pushCycle({nm, " trap"}, s, 1'b1, cin, rz, rn);
      end
    endcase
    opcode = op;
    while (in_q.size() > 0) begin
      {mem_ready, alu_carry, rs_zero, rs_neg} = in_q.pop_front();
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge: asserts reset mid-cycle and releases it later.
  task automatic doReset(input string nm);
    #2;
    rst       = 1'b1;
    m_carry   = 1'b0;
    m_retired = '0;
    #1;
    checkOutput({nm, " async"}, blank());
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput({nm, " released"}, blank());
    @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        checkOutput(mon_name, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; opcode = '0; mem_ready = 1'b0; alu_carry = 1'b0;
    rs_zero = 1'b0; rs_neg = 1'b0;
    m_carry = 1'b0; m_retired = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset", blank());
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("release_before_edge", blank());
    @(posedge clk);
    #1;

    applyStimulus("rtype",   T_R,    0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("lw_wait", T_LW,   0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("itype_c", T_I,    0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("bcy",     T_BCY,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("bncy",    T_BNCY, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("bl",      T_BL,   0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("sw",      T_SW,   2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("bz_t",    T_BZ,   0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("bnz_nt",  T_BNZ,  0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("bltz_t",  T_BLTZ, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("bltz_nt", T_BLTZ, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("br",      T_BR,   1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("b",       T_B,    0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("rtype_c0", T_R,   0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("bcy_nt",  T_BCY,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("itype_c1", T_I,   0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("sw_abort", T_SW,  0, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    doReset("abort_reset");
    applyStimulus("after_abort", T_R, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("illegal", T_ILL,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset("trap_reset");
    applyStimulus("halt",    T_HALT, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset("halt_reset");
    applyStimulus("final_lw", T_LW,  1, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
